// File: rtl/uart_rx_oversampled_pkg.sv
// Shared types and constants for the oversampled UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_oversampled_pkg;

  localparam int UART_DATA_BITS = 8;

  // Saturation limit of the 2-bit majority filter counter.
  localparam logic [1:0] FILT_MAX = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_oversampled_line_filter.sv
// rxd 2-flop synchroniser followed by a tick-driven saturating majority filter.
// Latency: 2 clk sync, then 3 ticks of a stable level to flip rxd_filt.
// Backpressure: none; runs freely, filter frozen between ticks.
module rx_line_filter
  import uart_rx_oversampled_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic rxd,
  output logic rxd_filt
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       filt_q, filt_d;

  // Next-state: shift the synchroniser every clk, step the filter on tick only.
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    fcnt_d  = fcnt_q;
    filt_d  = filt_q;
    if (tick) begin
      if (sync2_q && (fcnt_q != FILT_MAX)) begin
        fcnt_d = fcnt_q + 2'd1;
      end else if (!sync2_q && (fcnt_q != 2'd0)) begin
        fcnt_d = fcnt_q - 2'd1;
      end
      // Hysteresis: only the saturated ends change the output level.
      if (fcnt_d == 2'd0) begin
        filt_d = 1'b0;
      end else if (fcnt_d == FILT_MAX) begin
        filt_d = 1'b1;
      end
    end
  end

  // State registers; reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fcnt_q  <= FILT_MAX;
      filt_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fcnt_q  <= fcnt_d;
      filt_q  <= filt_d;
    end
  end

  assign rxd_filt = filt_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 LSB-first UART receiver on an oversampled tick, with data_ready/frame_err pulses.
// Latency: pulses one clk after the stop-bit sampling tick; each pulse is 1 clk wide.
// Backpressure: none; host must take data on data_ready, data holds until the next good byte.
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int OVERSAMPLING = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_ready,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rxd_filt;
  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      data_ready_q, data_ready_d;
  logic                      frame_err_q, frame_err_d;

  rx_line_filter u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .rxd      (rxd),
    .rxd_filt (rxd_filt)
  );

  // Frame FSM: all progress happens on tick cycles; pulses default low every clk.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    data_ready_d = 1'b0;
    frame_err_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_filt) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          // Mid-start-bit check rejects edges that do not last half a bit.
          if (cnt_q == CNT_MID) begin
            if (rxd_filt) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
              cnt_d     = '0;
              bit_idx_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            // Shift in at the MSB so the first (LSB) bit ends up in bit 0.
            shreg_d = {rxd_filt, shreg_q[UART_DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            if (rxd_filt) begin
              data_d       = shreg_q;
              data_ready_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rxd_filt) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign data_ready = data_ready_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: tick every 4th clk, one bit = 32 clk.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rxd;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         ready_cnt   = 0;
  int         ferr_cnt    = 0;
  int         both_cnt    = 0;
  int         busy_cycles = 0;
  logic [7:0] cap_prev    = 8'h00;
  logic [7:0] cap_last    = 8'h00;

  int r0, f0, b0;

  uart_rx_oversampled #(.OVERSAMPLING(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .rxd        (rxd),
    .data       (data),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one clk-wide tick every 4 clks, driven away from the active edge.
  initial begin
    int tdiv;
    tdiv = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = tdiv + 1;
      tick = ((tdiv % 4) == 0);
    end
  end

  // Output monitor: counts pulses, captures received bytes, tracks busy time.
  always @(negedge clk) begin
    if (data_ready) begin
      ready_cnt = ready_cnt + 1;
      cap_prev  = cap_last;
      cap_last  = data;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (data_ready && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cycles = busy_cycles + 1;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (32) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * 32) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("reset_data",  32'(data),       32'h00);
    check("reset_ready", 32'(data_ready), 32'h0);
    check("reset_ferr",  32'(frame_err),  32'h0);
    check("reset_busy",  32'(busy),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);

    // 1: single byte 0x55
    r0 = ready_cnt; f0 = ferr_cnt;
    send_byte(8'h55, 1'b1);
    idle_bits(1);
    check("t1_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    check("t1_data",         32'(data),           32'h55);
    check("t1_ferr_pulses",  32'(ferr_cnt - f0),  32'd0);
    check("t1_busy_after",   32'(busy),           32'h0);

    // 2: back-to-back 0xA3, 0x0F
    r0 = ready_cnt;
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    idle_bits(1);
    check("t2_ready_pulses", 32'(ready_cnt - r0), 32'd2);
    check("t2_first_byte",   32'(cap_prev),       32'hA3);
    check("t2_second_byte",  32'(cap_last),       32'h0F);
    check("t2_data",         32'(data),           32'h0F);

    // 3: 2-tick glitch is filtered out entirely
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_cycles;
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    idle_bits(1);
    check("t3_busy_cycles", 32'(busy_cycles - b0), 32'd0);
    check("t3_pulses",      32'((ready_cnt - r0) + (ferr_cnt - f0)), 32'd0);

    // 4: low pulse long enough to pass the filter but not the mid-start check
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_cycles;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    idle_bits(2);
    check("t4_entered_start", 32'((busy_cycles - b0) > 0), 32'd1);
    check("t4_ready_pulses",  32'(ready_cnt - r0),         32'd0);
    check("t4_ferr_pulses",   32'(ferr_cnt - f0),          32'd0);
    check("t4_busy_after",    32'(busy),                   32'h0);

    // 5: bad stop bit followed by a held-low line
    r0 = ready_cnt; f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (20 * 32) @(negedge clk);
    check("t5_ferr_pulses",  32'(ferr_cnt - f0),  32'd1);
    check("t5_ready_pulses", 32'(ready_cnt - r0), 32'd0);
    check("t5_data_held",    32'(data),           32'h0F);
    check("t5_busy_low",     32'(busy),           32'h1);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_busy_recover", 32'(busy),           32'h1);
    repeat (64) @(negedge clk);
    check("t5_busy_idle",    32'(busy),           32'h0);

    // 6: reset during data bit 4 of 0xFF, then a clean 0x81
    r0 = ready_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (16) @(negedge clk);
    check("t6_busy_midframe", 32'(busy), 32'h1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    #1;
    check("t6_rst_data",  32'(data),       32'h00);
    check("t6_rst_ready", 32'(data_ready), 32'h0);
    check("t6_rst_ferr",  32'(frame_err),  32'h0);
    check("t6_rst_busy",  32'(busy),       32'h0);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    check("t6_no_pulse_partial", 32'((ready_cnt - r0) + (ferr_cnt - f0)), 32'd0);
    r0 = ready_cnt;
    send_byte(8'h81, 1'b1);
    idle_bits(1);
    check("t6_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    check("t6_data",         32'(data),           32'h81);

    check("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
